// File: rtl/paws_rst_seq_if.sv
// Reset-sequencer bundle: PLL lock/sw request in, per-domain resets and status out.
// Latency: pure wiring, no storage.
// Backpressure: none; every signal is a level or a single-cycle pulse.
interface paws_rst_seq_if #(
  parameter int NUM_DOMAINS = 3
);
  logic                   pll_locked;
  logic                   sw_reset;
  logic [NUM_DOMAINS-1:0] domain_rst_n;
  logic                   all_ready;
  logic                   pll_rst;
  logic [2:0]             seq_state;
  logic [7:0]             lock_loss_count;

  // Driven by the board/PLL and software side; observes the sequencer.
  modport master (
    output pll_locked,
    output sw_reset,
    input  domain_rst_n,
    input  all_ready,
    input  pll_rst,
    input  seq_state,
    input  lock_loss_count
  );

  // The sequencer itself.
  modport slave (
    input  pll_locked,
    input  sw_reset,
    output domain_rst_n,
    output all_ready,
    output pll_rst,
    output seq_state,
    output lock_loss_count
  );
endinterface

// File: rtl/paws_rst_seq.sv
// PLL lock supervisor: filters lock, releases NUM_DOMAINS resets in order, re-resets PLL on timeout.
// Latency: lock_s lags pll_locked by 2 cycles; domain 0 releases LOCK_FILTER cycles after lock_s is seen.
// Backpressure: none; sw_reset is a one-cycle request honoured only while releasing or running.
module paws_rst_seq #(
  parameter int NUM_DOMAINS    = 3,
  parameter int LOCK_FILTER    = 1024,
  parameter int STEP_DELAY     = 16,
  parameter int RELOCK_TIMEOUT = 1048576,
  parameter int PLLRST_PULSE   = 16
) (
  input  logic          clkin,
  input  logic          reset_n,
  paws_rst_seq_if.slave bus
);

  // Shared counter must hold the largest terminal count of any state.
  localparam int MAX_AB = (LOCK_FILTER > STEP_DELAY) ? LOCK_FILTER : STEP_DELAY;
  localparam int MAX_CD = (RELOCK_TIMEOUT > PLLRST_PULSE) ? RELOCK_TIMEOUT : PLLRST_PULSE;
  localparam int MAXP   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAXP) + 1;
  localparam int IW     = $clog2(NUM_DOMAINS) + 1;

  // The WAIT_LOCK cycle that first sees lock counts as filter cycle 0, so
  // FILTER (entered with cnt=0) finishes one count early. LOCK_FILTER==1
  // releases straight out of WAIT_LOCK instead.
  localparam int FILT_LAST_I = (LOCK_FILTER >= 2) ? (LOCK_FILTER - 2) : 0;

  localparam logic [CW-1:0] C_FILT_LAST   = CW'(FILT_LAST_I);
  localparam logic [CW-1:0] C_STEP_LAST   = CW'(STEP_DELAY - 1);
  localparam logic [CW-1:0] C_RELOCK_LAST = CW'(RELOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] C_PULSE_LAST  = CW'(PLLRST_PULSE - 1);
  localparam logic [IW-1:0] C_IDX_LAST    = IW'(NUM_DOMAINS - 1);

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_FILTER    = 3'd1,
    S_RELEASE   = 3'd2,
    S_RUN       = 3'd3,
    S_PLLRST    = 3'd4
  } state_t;

  // Registered state and outputs
  logic                   r_sync1;
  logic                   r_sync2;
  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic [IW-1:0]          r_idx;
  logic [NUM_DOMAINS-1:0] r_dom;
  logic                   r_ready;
  logic                   r_pll_rst;
  logic [7:0]             r_loss_cnt;

  // Next-state values
  logic                   w_lock_s;
  logic                   w_active;
  logic                   w_first_rel;
  state_t                 w_state_nxt;
  logic [CW-1:0]          w_cnt_nxt;
  logic [IW-1:0]          w_idx_nxt;
  logic [NUM_DOMAINS-1:0] w_dom_nxt;
  logic                   w_ready_nxt;
  logic [7:0]             w_loss_nxt;

  assign w_lock_s = r_sync2;
  assign w_active = (r_state == S_RELEASE) || (r_state == S_RUN);

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bus.pll_locked;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state, counter, release mask and loss counter.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_dom_nxt   = r_dom;
    w_ready_nxt = r_ready;
    w_loss_nxt  = r_loss_cnt;
    w_first_rel = 1'b0;

    case (r_state)
      S_WAIT_LOCK: begin
        w_dom_nxt   = '0;
        w_ready_nxt = 1'b0;
        w_idx_nxt   = '0;
        if (w_lock_s) begin
          if (LOCK_FILTER == 1) begin
            w_first_rel = 1'b1;
          end else begin
            w_state_nxt = S_FILTER;
            w_cnt_nxt   = '0;
          end
        end else if (r_cnt == C_RELOCK_LAST) begin
          w_state_nxt = S_PLLRST;
          w_cnt_nxt   = '0;
        end
      end

      S_FILTER: begin
        // A drop while filtering is just an unstable lock, not a loss.
        if (!w_lock_s) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_FILT_LAST) begin
          w_first_rel = 1'b1;
        end
      end

      S_RELEASE: begin
        if (r_cnt == C_STEP_LAST) begin
          w_dom_nxt = r_dom | (NUM_DOMAINS'(1) << r_idx);
          w_idx_nxt = r_idx + 1'b1;
          w_cnt_nxt = '0;
          if (r_idx == C_IDX_LAST) begin
            w_state_nxt = S_RUN;
            w_ready_nxt = 1'b1;
          end
        end
      end

      S_RUN: begin
        w_cnt_nxt = '0;
      end

      S_PLLRST: begin
        // Lock is deliberately ignored while the PLL is held in reset.
        w_dom_nxt   = '0;
        w_ready_nxt = 1'b0;
        if (r_cnt == C_PULSE_LAST) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end
      end

      default: begin
        w_state_nxt = S_WAIT_LOCK;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
        w_dom_nxt   = '0;
        w_ready_nxt = 1'b0;
      end
    endcase

    // End of filtering: domain 0 comes out of reset on this edge.
    if (w_first_rel) begin
      w_dom_nxt = NUM_DOMAINS'(1);
      w_idx_nxt = IW'(1);
      w_cnt_nxt = '0;
      if (NUM_DOMAINS == 1) begin
        w_state_nxt = S_RUN;
        w_ready_nxt = 1'b1;
      end else begin
        w_state_nxt = S_RELEASE;
      end
    end

    // Lock loss outranks a software request arriving on the same edge.
    if (w_active) begin
      if (!w_lock_s) begin
        w_state_nxt = S_WAIT_LOCK;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
        w_dom_nxt   = '0;
        w_ready_nxt = 1'b0;
        if (r_loss_cnt != 8'hFF) begin
          w_loss_nxt = r_loss_cnt + 1'b1;
        end
      end else if (bus.sw_reset) begin
        w_state_nxt = S_FILTER;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
        w_dom_nxt   = '0;
        w_ready_nxt = 1'b0;
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_WAIT_LOCK;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_dom      <= '0;
      r_ready    <= 1'b0;
      r_pll_rst  <= 1'b0;
      r_loss_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_dom      <= w_dom_nxt;
      r_ready    <= w_ready_nxt;
      r_pll_rst  <= (w_state_nxt == S_PLLRST);
      r_loss_cnt <= w_loss_nxt;
    end
  end

  assign bus.domain_rst_n    = r_dom;
  assign bus.all_ready       = r_ready;
  assign bus.pll_rst         = r_pll_rst;
  assign bus.seq_state       = r_state;
  assign bus.lock_loss_count = r_loss_cnt;

endmodule
